cmd_frame_master: RTL and testbench
===================================

Name: cmd_frame_master

Overview:
- Host-side initiator for the UART command protocol that the system controller decodes.
- Accepts one command at a time on a parallel request interface and serialises it into protocol frames on a byte-wide UART TX handshake:
  - 0xAA write
  - 0xBB read
  - 0xCC ALU with operands
  - 0xDD ALU without operands
- Collects the 1- or 2-byte response from the UART RX byte stream and returns it as one 16-bit result.
- Sits between a test/host sequencer and the host-side UART TX/RX pair.

Parameters:
- TIMEOUT_CYCLES, 4096, max CLK cycles waited for each response byte before error.
- TO_CNT_W, 16, width of timeout counter; must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-low
- CMD_VLD  input  1  command request
- CMD_RDY  output  1  block idle, command accepted when CMD_VLD&&CMD_RDY
- CMD_TYPE  input  2  0=WRITE, 1=READ, 2=ALU_W_OP, 3=ALU_NO_OP
- CMD_ADDR  input  4  register-file address (WRITE/READ)
- CMD_A  input  8  write data (WRITE) or operand A (ALU_W_OP)
- CMD_B  input  8  operand B (ALU_W_OP)
- CMD_FUN  input  4  ALU function (ALU types)
- TX_DATA  output  8  byte to UART TX
- TX_VLD  output  1  TX_DATA valid
- TX_RDY  input  1  UART TX accepts byte this cycle
- RX_DATA  input  8  received byte
- RX_VLD  input  1  single-cycle strobe, RX_DATA valid
- RSP_DATA  output  16  response value
- RSP_VLD  output  1  one-cycle pulse, RSP_DATA updated
- RSP_ERR  output  1  one-cycle pulse, response timeout
- CMD_DONE  output  1  one-cycle pulse, command finished (success or error)

Behaviour:
- Reset (async, RST=0): state IDLE; TX_VLD=0, TX_DATA=0, RSP_DATA=0, RSP_VLD=0, RSP_ERR=0, CMD_DONE=0, CMD_RDY=1, byte index=0, timeout counter=0. Reset mid-frame aborts with no further TX bytes.
- CMD_RDY=1 only in IDLE. On accept, all CMD_* fields are latched; inputs are don't-care afterwards.
- Frame byte sequences; address/function bytes are zero-extended nibbles:
  - WRITE: AA, {0,ADDR}, A
  - READ: BB, {0,ADDR}
  - ALU_W_OP: CC, A, B, {0,FUN}
  - ALU_NO_OP: DD, {0,FUN}
- States: IDLE -> SEND -> (WAIT_LO -> [WAIT_HI]) -> IDLE.
- SEND:
  - TX_VLD and TX_DATA are registered. The first byte is presented the cycle after accept.
  - A byte is transferred when TX_VLD&&TX_RDY. The next byte appears the following cycle with TX_VLD held high, giving back-to-back bytes.
  - TX_DATA is stable while TX_VLD=1 and TX_RDY=0.
  - After the last byte transfers, TX_VLD=0 next cycle.
- Completion per type:
  - WRITE: CMD_DONE pulses the cycle after the last byte transfers; returns to IDLE. RSP_DATA unchanged, no RSP_VLD.
  - READ: WAIT_LO. On RX_VLD, next cycle RSP_DATA={8'h00,RX_DATA}, RSP_VLD=1, CMD_DONE=1; return to IDLE.
  - ALU types: WAIT_LO captures the low byte into RSP_DATA[7:0] internally, then WAIT_HI. On RX_VLD, next cycle RSP_DATA={RX_DATA,lo}, RSP_VLD=1, CMD_DONE=1; return to IDLE.
- RX_VLD outside WAIT_LO/WAIT_HI, including the cycle the last TX byte transfers, is ignored.
- Timeout:
  - The counter clears on entering each WAIT state and on every captured byte, and increments each waiting cycle.
  - Reaching TIMEOUT_CYCLES without RX_VLD: next cycle RSP_ERR=1, CMD_DONE=1, RSP_VLD=0, RSP_DATA unchanged; return to IDLE.
  - RX_VLD in the same cycle the count reaches TIMEOUT_CYCLES counts as a received byte, not a timeout.
- CMD_RDY returns high in the cycle CMD_DONE pulses. A new CMD_VLD that cycle is accepted.
- RSP_VLD, RSP_ERR and CMD_DONE are never high for more than one cycle.

Optional Feature:
- Macro CMD_FRAME_MASTER_TIMEOUT_EN.
- Defined: timeout counter and RSP_ERR behave as above.
- Undefined: no counter is synthesised; WAIT states wait indefinitely; RSP_ERR is tied 0.

Test Plan:
- WRITE addr=5 data=0x3C, TX_RDY=1 always -> TX bytes AA,05,3C on 3 consecutive cycles; CMD_DONE 1 cycle later; no RSP_VLD.
- READ addr=2, TX_RDY toggling 1/0, RX byte 0x7E after 10 cycles -> TX bytes BB,02 each held stable while TX_RDY=0; RSP_DATA=0x007E, RSP_VLD and CMD_DONE pulse together.
- ALU_W_OP A=0x10 B=0x20 FUN=0 -> TX CC,10,20,00; RX 0x30 then 0x00 -> RSP_DATA=0x0030. ALU_NO_OP FUN=2 -> TX DD,02; RX 0x00,0x02 -> RSP_DATA=0x0200.
- READ with no RX (macro defined, TIMEOUT_CYCLES=16) -> RSP_ERR+CMD_DONE exactly 16 cycles after entering WAIT_LO; RSP_DATA unchanged; CMD_RDY=1. Macro undefined -> block stays in wait, CMD_RDY=0.
- Stray RX_VLD (0x55) in IDLE and during SEND of a READ, then real response 0x11 -> RSP_DATA=0x0011.
- RST low during the second byte of an ALU_W_OP frame -> TX_VLD=0 immediately, CMD_RDY=1; next WRITE command frames correctly from AA.

Source files
------------

// File: rtl/cmd_frame_master.sv
// Host-side UART command frame initiator: serialises one command into a byte frame and collects the 1/2-byte response.
// Optional macro CMD_FRAME_MASTER_TIMEOUT_EN enables the per-byte response timeout and RSP_ERR.
module cmd_frame_master #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_CNT_W       = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VLD,
    output logic        CMD_RDY,
    input  logic [1:0]  CMD_TYPE,
    input  logic [3:0]  CMD_ADDR,
    input  logic [7:0]  CMD_A,
    input  logic [7:0]  CMD_B,
    input  logic [3:0]  CMD_FUN,
    output logic [7:0]  TX_DATA,
    output logic        TX_VLD,
    input  logic        TX_RDY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VLD,
    output logic [15:0] RSP_DATA,
    output logic        RSP_VLD,
    output logic        RSP_ERR,
    output logic        CMD_DONE
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_LO, WAIT_HI} state_e;
    typedef enum logic [1:0] {CMD_WRITE, CMD_READ, CMD_ALU_W_OP, CMD_ALU_NO_OP} cmd_type_e;

    if (TIMEOUT_CYCLES >= (2 ** TO_CNT_W)) begin : g_cfg_check
        $error("cmd_frame_master: TO_CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e    state_q, state_d;
    cmd_type_e type_q, type_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [3:0]  fun_q, fun_d;
    logic [1:0]  idx_q, idx_d;
    logic        tx_vld_q, tx_vld_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cmd_done_q, cmd_done_d;

`ifdef CMD_FRAME_MASTER_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

    function automatic logic [7:0] frame_byte(input logic [1:0] t, input logic [1:0] idx,
                                              input logic [3:0] addr, input logic [7:0] a,
                                              input logic [7:0] b, input logic [3:0] fun);
        logic [7:0] r;
        r = 8'h00;
        case (t)
            CMD_WRITE:    r = (idx == 2'd0) ? 8'hAA : (idx == 2'd1) ? {4'h0, addr} : a;
            CMD_READ:     r = (idx == 2'd0) ? 8'hBB : {4'h0, addr};
            CMD_ALU_W_OP: r = (idx == 2'd0) ? 8'hCC : (idx == 2'd1) ? a :
                              (idx == 2'd2) ? b : {4'h0, fun};
            default:      r = (idx == 2'd0) ? 8'hDD : {4'h0, fun};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] t);
        logic [1:0] r;
        case (t)
            CMD_WRITE:    r = 2'd2;
            CMD_ALU_W_OP: r = 2'd3;
            default:      r = 2'd1;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        a_d        = a_q;
        b_d        = b_q;
        fun_d      = fun_q;
        idx_d      = idx_q;
        tx_vld_d   = tx_vld_q;
        tx_data_d  = tx_data_q;
        lo_d       = lo_q;
        rsp_data_d = rsp_data_q;
        rsp_vld_d  = 1'b0;
        rsp_err_d  = 1'b0;
        cmd_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (CMD_VLD) begin
                    type_d    = cmd_type_e'(CMD_TYPE);
                    addr_d    = CMD_ADDR;
                    a_d       = CMD_A;
                    b_d       = CMD_B;
                    fun_d     = CMD_FUN;
                    idx_d     = 2'd0;
                    tx_vld_d  = 1'b1;
                    tx_data_d = frame_byte(CMD_TYPE, 2'd0, CMD_ADDR, CMD_A, CMD_B, CMD_FUN);
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_vld_q && TX_RDY) begin
                    if (idx_q == last_idx(type_q)) begin
                        tx_vld_d = 1'b0;
                        idx_d    = 2'd0;
                        if (type_q == CMD_WRITE) begin
                            cmd_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = WAIT_LO;
                        end
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = frame_byte(type_q, idx_q + 2'd1, addr_q, a_q, b_q, fun_q);
                    end
                end
            end
            WAIT_LO: begin
                if (RX_VLD) begin
                    if (type_q == CMD_READ) begin
                        rsp_data_d = {8'h00, RX_DATA};
                        rsp_vld_d  = 1'b1;
                        cmd_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        lo_d    = RX_DATA;
                        state_d = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (RX_VLD) begin
                    rsp_data_d = {RX_DATA, lo_q};
                    rsp_vld_d  = 1'b1;
                    cmd_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef CMD_FRAME_MASTER_TIMEOUT_EN
        // Counter is zero outside an idle wait, so entering a wait state or capturing a byte restarts it.
        to_cnt_d = '0;
        if ((state_q == WAIT_LO || state_q == WAIT_HI) && !RX_VLD) begin
            if (to_cnt_q == TO_LAST) begin
                rsp_err_d  = 1'b1;
                cmd_done_d = 1'b1;
                state_d    = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            type_q     <= CMD_WRITE;
            addr_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            idx_q      <= '0;
            tx_vld_q   <= 1'b0;
            tx_data_q  <= '0;
            lo_q       <= '0;
            rsp_data_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            cmd_done_q <= 1'b0;
`ifdef CMD_FRAME_MASTER_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fun_q      <= fun_d;
            idx_q      <= idx_d;
            tx_vld_q   <= tx_vld_d;
            tx_data_q  <= tx_data_d;
            lo_q       <= lo_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            cmd_done_q <= cmd_done_d;
`ifdef CMD_FRAME_MASTER_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign CMD_RDY  = (state_q == IDLE);
    assign TX_VLD   = tx_vld_q;
    assign TX_DATA  = tx_data_q;
    assign RSP_DATA = rsp_data_q;
    assign RSP_VLD  = rsp_vld_q;
    assign RSP_ERR  = rsp_err_q;
    assign CMD_DONE = cmd_done_q;

endmodule

// File: tb/tb_cmd_frame_master.sv
// Scoreboard bench for cmd_frame_master: stimulus queues expected TX bytes and responses, a negedge monitor checks them.
// Timeout section adapts to whether CMD_FRAME_MASTER_TIMEOUT_EN is defined.
module tb_cmd_frame_master;

    localparam int TO = 16;

    typedef struct {
        logic        vld;
        logic        err;
        logic [15:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_type = 2'd0;
    logic [3:0]  cmd_addr = 4'd0;
    logic [7:0]  cmd_a = 8'd0;
    logic [7:0]  cmd_b = 8'd0;
    logic [3:0]  cmd_fun = 4'd0;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_vld = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_vld;
    logic        rsp_err;
    logic        cmd_done;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int done_count = 0;
    int done_cycle = 0;
    int accept_cycle = 0;
    int last_xfer_cycle = 0;
    int rdy_mode = 1;
    logic rdy_toggle = 1'b1;
    logic [15:0] last_rsp = 16'h0000;
    logic [7:0] exp_tx[$];
    rsp_t exp_rsp[$];
    int xfer_cycles[$];
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    cmd_frame_master #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(16)) dut (
        .CLK(clk), .RST(rst_n),
        .CMD_VLD(cmd_vld), .CMD_RDY(cmd_rdy), .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr),
        .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_FUN(cmd_fun),
        .TX_DATA(tx_data), .TX_VLD(tx_vld), .TX_RDY(tx_rdy),
        .RX_DATA(rx_data), .RX_VLD(rx_vld),
        .RSP_DATA(rsp_data), .RSP_VLD(rsp_vld), .RSP_ERR(rsp_err), .CMD_DONE(cmd_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rdy_toggle = ~rdy_toggle;
    end

    assign tx_rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? rdy_toggle : 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: TX stall stability, TX byte order, and response/done pulses against the queues.
    always @(negedge clk) begin
        if (prev_stall) begin
            check_output("tx_hold_vld", 32'(tx_vld), 32'd1);
            check_output("tx_hold_data", 32'(tx_data), 32'(prev_data));
        end
        prev_stall = tx_vld && !tx_rdy;
        prev_data  = tx_data;
        if (tx_vld && tx_rdy) begin
            xfer_cycles.push_back(cyc);
            last_xfer_cycle = cyc;
            if (exp_tx.size() == 0) begin
                check_output("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                check_output("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
        end
        if (rsp_vld || rsp_err || cmd_done) begin
            done_count++;
            done_cycle = cyc;
            if (exp_rsp.size() == 0) begin
                check_output("rsp_unexpected", {13'd0, rsp_vld, rsp_err, cmd_done}, 32'hFFFF_FFFF);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                check_output("rsp_vld", 32'(rsp_vld), 32'(e.vld));
                check_output("rsp_err", 32'(rsp_err), 32'(e.err));
                check_output("cmd_done", 32'(cmd_done), 32'd1);
                check_output("rsp_data", 32'(rsp_data), 32'(e.data));
                check_output("rdy_at_done", 32'(cmd_rdy), 32'd1);
            end
        end
    end

    task automatic push_rsp(input logic vld, input logic err, input logic [15:0] data);
        rsp_t r;
        r.vld = vld;
        r.err = err;
        r.data = data;
        exp_rsp.push_back(r);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
    task automatic apply_stimulus(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] a,
                                  input logic [7:0] b, input logic [3:0] fun);
        bit ok;
        int tries;
        case (t)
            2'd0: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr}); exp_tx.push_back(a); end
            2'd1: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr}); end
            2'd2: begin exp_tx.push_back(8'hCC); exp_tx.push_back(a); exp_tx.push_back(b);
                        exp_tx.push_back({4'h0, fun}); end
            default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fun}); end
        endcase
        cmd_type = t; cmd_addr = addr; cmd_a = a; cmd_b = b; cmd_fun = fun;
        cmd_vld = 1'b1;
        ok = 1'b0;
        tries = 0;
        while (!ok && tries < 50) begin
            ok = cmd_rdy;
            @(posedge clk); #1;
            tries++;
        end
        accept_cycle = cyc;
        cmd_vld = 1'b0;
        cmd_type = ~t; cmd_addr = 4'hE; cmd_a = 8'h99; cmd_b = 8'h66; cmd_fun = 4'hB;
        if (!ok) check_output("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] d, input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        rx_vld = 1'b1;
        rx_data = d;
        @(posedge clk); #1;
        rx_vld = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_vld && n < 100) begin @(posedge clk); #1; n++; end
        if (tx_vld) check_output("tx_idle_timeout", 32'(tx_vld), 32'd0);
    endtask

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (done_count == start && n < 300) begin @(posedge clk); #1; n++; end
        if (done_count == start) check_output("done_timeout", 32'(done_count), 32'(start + 1));
    endtask

    initial begin
        int start;
        repeat (3) begin @(posedge clk); #1; end
        check_output("reset_tx_vld", 32'(tx_vld), 32'd0);
        check_output("reset_tx_data", 32'(tx_data), 32'd0);
        check_output("reset_rsp_data", 32'(rsp_data), 32'd0);
        check_output("reset_pulses", {29'd0, rsp_vld, rsp_err, cmd_done}, 32'd0);
        check_output("reset_cmd_rdy", 32'(cmd_rdy), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // WRITE addr 5 data 3C, back-to-back bytes and done one cycle after the last
        rdy_mode = 1;
        xfer_cycles.delete();
        start = done_count;
        push_rsp(1'b0, 1'b0, last_rsp);
        apply_stimulus(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
        wait_done(start);
        check_output("wr_xfer_count", 32'(xfer_cycles.size()), 32'd3);
        if (xfer_cycles.size() == 3) begin
            check_output("wr_first_byte_cycle", 32'(xfer_cycles[0]), 32'(accept_cycle));
            check_output("wr_b2b_1", 32'(xfer_cycles[1] - xfer_cycles[0]), 32'd1);
            check_output("wr_b2b_2", 32'(xfer_cycles[2] - xfer_cycles[1]), 32'd1);
            check_output("wr_done_lat", 32'(done_cycle - xfer_cycles[2]), 32'd1);
        end

        // READ addr 2 with TX_RDY toggling, response 7E after 10 cycles
        rdy_mode = 2;
        start = done_count;
        push_rsp(1'b1, 1'b0, 16'h007E);
        apply_stimulus(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
        wait_tx_idle();
        send_rx(8'h7E, 10);
        wait_done(start);
        last_rsp = 16'h007E;
        rdy_mode = 1;

        // ALU_W_OP 10+20, response lo 30 hi 00
        start = done_count;
        push_rsp(1'b1, 1'b0, 16'h0030);
        apply_stimulus(2'd2, 4'h0, 8'h10, 8'h20, 4'h0);
        wait_tx_idle();
        send_rx(8'h30, 2);
        send_rx(8'h00, 1);
        wait_done(start);

        // ALU_NO_OP fun 2, response lo 00 hi 02
        start = done_count;
        push_rsp(1'b1, 1'b0, 16'h0200);
        apply_stimulus(2'd3, 4'h0, 8'h00, 8'h00, 4'h2);
        wait_tx_idle();
        send_rx(8'h00, 3);
        send_rx(8'h02, 0);
        wait_done(start);

        // Stray RX in IDLE and during a stalled SEND
        send_rx(8'h55, 1);
        rdy_mode = 0;
        start = done_count;
        push_rsp(1'b1, 1'b0, 16'h0011);
        apply_stimulus(2'd1, 4'hA, 8'h00, 8'h00, 4'h0);
        send_rx(8'h55, 0);
        rdy_mode = 1;
        wait_tx_idle();
        send_rx(8'h11, 3);
        wait_done(start);

        // Stray RX in the cycle the last READ byte transfers
        start = done_count;
        push_rsp(1'b1, 1'b0, 16'h0022);
        apply_stimulus(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
        send_rx(8'h66, 1);
        send_rx(8'h22, 2);
        wait_done(start);
        last_rsp = 16'h0022;

        // READ with no response
        start = done_count;
`ifdef CMD_FRAME_MASTER_TIMEOUT_EN
        push_rsp(1'b0, 1'b1, last_rsp);
        apply_stimulus(2'd1, 4'h1, 8'h00, 8'h00, 4'h0);
        wait_tx_idle();
        wait_done(start);
        check_output("timeout_latency", 32'(done_cycle - last_xfer_cycle), 32'(TO + 1));
`else
        apply_stimulus(2'd1, 4'h1, 8'h00, 8'h00, 4'h0);
        wait_tx_idle();
        repeat (40) begin @(posedge clk); #1; end
        check_output("wait_forever_rdy", 32'(cmd_rdy), 32'd0);
        check_output("wait_forever_done", 32'(done_count), 32'(start));
        rst_n = 1'b0;
        #1;
        check_output("wait_reset_rdy", 32'(cmd_rdy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        last_rsp = 16'h0000;
`endif

        // Reset during the second byte of an ALU_W_OP frame
        rdy_mode = 1;
        apply_stimulus(2'd2, 4'h0, 8'h44, 8'h55, 4'h7);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_output("mid_reset_tx_vld", 32'(tx_vld), 32'd0);
        check_output("mid_reset_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check_output("mid_reset_bytes_left", 32'(exp_tx.size()), 32'd3);
        exp_tx.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        last_rsp = 16'h0000;
        start = done_count;
        push_rsp(1'b0, 1'b0, last_rsp);
        apply_stimulus(2'd0, 4'hF, 8'hA5, 8'h00, 4'h0);
        wait_done(start);

        repeat (5) begin @(posedge clk); #1; end
        check_output("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        check_output("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
